// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sprite/background ROM among
// N_REQ pixel fetchers. Each read is tagged with its owner so the data comes back to that requester only.
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      prio_en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [N_REQ-1:0]          gnt,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy
);

  localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TAG_DEPTH = RD_LAT + 1;

  logic [IDX_W-1:0]  last_q, last_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [TAG_DEPTH-1:0] tag_vld_q;
  logic [IDX_W-1:0]  tag_own_q [TAG_DEPTH];

  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
    assign gnt[gi]      = win_vld && (win_idx == IDX_W'(gi));
    assign rvalid[gi]   = tag_vld_q[TAG_DEPTH-1] && (tag_own_q[TAG_DEPTH-1] == IDX_W'(gi));
  end

  // Reset suppresses the grant combinationally so nothing is issued in a reset cycle.
  always_comb begin
    int cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    if (!Reset && (req != '0)) begin
      if (prio_en && req[0]) begin
        win_vld = 1'b1;
      end else begin
        for (int k = 1; k <= N_REQ; k++) begin
          cand = (int'(last_q) + k) % N_REQ;
          if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(cand);
          end
        end
      end
    end
  end

  always_comb begin
    last_d     = last_q;
    mem_rd_d   = win_vld;
    mem_addr_d = mem_addr_q;
    if (win_vld) begin
      last_d     = win_idx;
      mem_addr_d = addr_arr[win_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q     <= IDX_W'(N_REQ - 1);
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      tag_vld_q  <= '0;
      for (int k = 0; k < TAG_DEPTH; k++) tag_own_q[k] <= '0;
    end else begin
      last_q     <= last_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      tag_vld_q  <= {tag_vld_q[TAG_DEPTH-2:0], win_vld};
      tag_own_q[0] <= win_idx;
      for (int k = 1; k < TAG_DEPTH; k++) tag_own_q[k] <= tag_own_q[k-1];
    end
  end

  // The last tag stage lines up with mem_rdata RD_LAT cycles after mem_rd.
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign rdata    = (|rvalid) ? mem_rdata : '0;
  assign busy     = mem_rd_q | (|tag_vld_q);

endmodule
